pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Parametrised, fully pipelined barrel shifter: WIDTH-bit data, log2(WIDTH) registered shift stages.
//  Five shift/rotate modes selected per transaction; valid/ready on input and output.
//  Sits in the datapath between an operand source and a result sink.
//  Accepts one operation per clock when not back-pressured.
// PARAMETERS
//  WIDTH    8                Data width; power of two, >= 2.
//  SHAMT_W  $clog2(WIDTH)    Shift-amount width (derived, do not override); also pipeline depth.
// PORTS
//  clk        in   1        Single clock; all state on rising edge.
//  rst        in   1        Synchronous, active-high reset.
//  in_valid   in   1        Input transaction present.
//  in_ready   out  1        Shifter can accept; transfer when in_valid && in_ready.
//  datain     in   WIDTH    Operand.
//  shiftamt   in   SHAMT_W  Shift amount, 0..WIDTH-1.
//  shifttype  in   3        000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through.
//  out_valid  out  1        Result present.
//  out_ready  in   1        Sink accepts; transfer when out_valid && out_ready.
//  dataout    out  WIDTH    Result.
//  out_zero   out  1        1 when dataout == 0 (qualified by out_valid).
// BEHAVIOUR
//  Reset: all stage valid bits, out_valid, dataout, out_zero = 0; in-flight ops discarded.
//  Reset forces in_ready = 0 in the reset cycle.
//  Stage k (k = 0..SHAMT_W-1): shifts by 2^k when shiftamt[k] = 1, else passes; result registered.
//  Each stage carries its valid bit, shifttype and the remaining shiftamt bits.
//  Decompose by amount bits only; never use a variable-shift operator.
//  Latency: op accepted in cycle 0 -> out_valid in cycle SHAMT_W (3 for WIDTH=8), no stall.
//  Throughput: 1 op/cycle.
//  Stall: en = !out_valid || out_ready; in_ready = en && !rst.
//  en = 0 freezes every stage (data, valid, ctrl) and holds dataout/out_valid stable.
//  Bubbles are not collapsed; invalid slots travel through like data.
//  SLL/SRL: zero-fill. SRA: fill with datain[WIDTH-1] at every stage.
//  ROL/ROR: bits wrap; shiftamt=0 is identity for all modes.
//  Pass-through codes: dataout = datain, amount ignored.
//  out_zero is registered alongside dataout in the final stage.
//  Simultaneous out handshake + new input: both transfer same edge; pipeline advances.
//  Reset mid-operation: all valids clear next edge regardless of en; no partial output appears.
// TESTING
//  T1 WIDTH=8, datain=8'b11100101, shiftamt=3, each mode 000..100 back-to-back, out_ready=1
//     -> dataout 00101000, 00011100, 11111100, 00101111, 10111100.
//     Each appears exactly 3 cycles after acceptance, in order.
//  T2 shiftamt=0, all modes; shifttype=111 with shiftamt=5
//     -> dataout = datain (11100101) every case.
//  T3 datain=8'h01, SLL by 7 -> 8'h80; SLL 8'h80 by 1 -> 8'h00 with out_zero=1.
//     SRA 8'h80 by 7 -> 8'hFF.
//  T4 stream 6 ops, hold out_ready=0 for 4 cycles mid-stream
//     -> in_ready=0 while out_valid && !out_ready; dataout stable.
//     No op lost or duplicated; order preserved.
//  T5 assert rst for 1 cycle with 3 ops in flight
//     -> out_valid=0 next cycle, no stale result ever emitted.
//     Next accepted op emerges after 3 cycles.
//  T6 WIDTH=32 (SHAMT_W=5): ROR 32'h8000_0001 by 1 -> 32'hC000_0000, latency 5 cycles.
//     Random ops vs reference model, 10k ops with random out_ready.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: one registered stage per shift-amount bit,
// valid/ready on both sides, a single global enable stalls the whole pipe.
module pipelined_barrel_shifter #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   datain,
   input  logic [SHAMT_W-1:0] shiftamt,
   input  logic [2:0]         shifttype,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   dataout,
   output logic               out_zero
);

   typedef enum logic [2:0] {
      SH_SLL = 3'b000,
      SH_SRL = 3'b001,
      SH_SRA = 3'b010,
      SH_ROL = 3'b011,
      SH_ROR = 3'b100
   } shift_e;

   logic en;
   logic zero_q;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      localparam int S = 1 << k;

      logic [WIDTH-1:0]   src;
      logic [2:0]         typ;
      logic [SHAMT_W-1:k] amt;
      logic               vld;
      logic [WIDTH-1:0]   sll_w, srl_w, sra_w, rol_w, ror_w;
      logic [WIDTH-1:0]   res;
      logic [WIDTH-1:0]   data_q;
      logic               valid_q;

      if (k == 0) begin : g_head
         assign src = datain;
         assign typ = shifttype;
         assign amt = shiftamt;
         assign vld = in_valid && in_ready;
      end else begin : g_tail
         assign src = g_stage[k-1].data_q;
         assign typ = g_stage[k-1].g_ctl.type_q;
         assign amt = g_stage[k-1].g_ctl.amt_q;
         assign vld = g_stage[k-1].valid_q;
      end

      // SRA keeps the MSB at every stage, so the running MSB is always datain's sign bit.
      assign sll_w = {src[WIDTH-S-1:0], {S{1'b0}}};
      assign srl_w = {{S{1'b0}}, src[WIDTH-1:S]};
      assign sra_w = {{S{src[WIDTH-1]}}, src[WIDTH-1:S]};
      assign rol_w = {src[WIDTH-S-1:0], src[WIDTH-1:WIDTH-S]};
      assign ror_w = {src[S-1:0], src[WIDTH-1:S]};

      // NOTE: default first so every path assigns res and no latch is inferred.
      always_comb begin
         res = src;
         if (amt[k]) begin
            case (typ)
               SH_SLL:  res = sll_w;
               SH_SRL:  res = srl_w;
               SH_SRA:  res = sra_w;
               SH_ROL:  res = rol_w;
               SH_ROR:  res = ror_w;
               default: res = src;
            endcase
         end
      end

      // NOTE: only valid bits and the visible output are reset; mid-pipe data is
      // don't-care while its valid is low, so it needs no reset.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            if (k == SHAMT_W - 1) data_q <= '0;
         end else if (en) begin
            valid_q <= vld;
            data_q  <= res;
         end
      end

      if (k < SHAMT_W - 1) begin : g_ctl
         logic [2:0]           type_q;
         logic [SHAMT_W-1:k+1] amt_q;

         always_ff @(posedge clk) begin
            if (en) begin
               type_q <= typ;
               amt_q  <= amt[SHAMT_W-1:k+1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)     zero_q <= 1'b0;
      else if (en) zero_q <= ~|g_stage[SHAMT_W-1].res;
   end

   assign out_valid = g_stage[SHAMT_W-1].valid_q;
   assign dataout   = g_stage[SHAMT_W-1].data_q;
   assign out_zero  = zero_q;
   assign en        = !out_valid || out_ready;
   assign in_ready  = en && !rst;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: an 8-bit and a 32-bit instance
// checked against an index-based reference model.
module tb_pipelined_barrel_shifter;

   typedef struct {
      logic [31:0] exp;
      int          cyc;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
   logic [7:0]  datain8 = '0, exp8_cur = '0;
   logic [2:0]  shamt8 = '0, type8 = '0;
   logic        in_ready8, out_valid8, out_zero8;
   logic [7:0]  dataout8;

   logic        in_valid32 = 1'b0, out_ready32 = 1'b1;
   logic [31:0] datain32 = '0, exp32_cur = '0;
   logic [4:0]  shamt32 = '0;
   logic [2:0]  type32 = '0;
   logic        in_ready32, out_valid32, out_zero32;
   logic [31:0] dataout32;

   bit lat_chk8 = 0, lat_chk32 = 0, rnd_rdy = 0;
   item_t q8[$];
   item_t q32[$];

   pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .datain(datain8), .shiftamt(shamt8), .shifttype(type8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .dataout(dataout8), .out_zero(out_zero8)
   );

   pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .datain(datain32), .shiftamt(shamt32), .shifttype(type32),
      .out_valid(out_valid32), .out_ready(out_ready32),
      .dataout(dataout32), .out_zero(out_zero32)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Bit-by-bit source-index model, independent of the stage decomposition.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int w,
                                             input int s, input logic [2:0] t);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (t)
            3'd0:    r[i] = (i >= s)    ? d[i-s] : 1'b0;
            3'd1:    r[i] = (i + s < w) ? d[i+s] : 1'b0;
            3'd2:    r[i] = (i + s < w) ? d[i+s] : d[w-1];
            3'd3:    r[i] = d[(i - s + w) % w];
            3'd4:    r[i] = d[(i + s) % w];
            default: r[i] = d[i];
         endcase
      end
      return r;
   endfunction

   logic       hold8 = 1'b0;
   logic [7:0] held8 = '0;
   always @(negedge clk) begin
      item_t it;
      if (rst) begin
         check("rst_in_ready8", in_ready8, 0);
         q8.delete();
         hold8 = 1'b0;
      end else begin
         check("in_ready8", in_ready8, !out_valid8 || out_ready8);
         if (hold8) begin
            check("stall_valid8", out_valid8, 1);
            check("stall_data8", dataout8, held8);
         end
         if (out_valid8 && out_ready8) begin
            if (q8.size() == 0) check("unexpected_out8", out_valid8, 0);
            else begin
               it = q8.pop_front();
               check("data8", dataout8, it.exp);
               check("zero8", out_zero8, it.exp == 0);
               if (lat_chk8) check("latency8", cyc - it.cyc, 3);
            end
         end
         if (in_valid8 && in_ready8) q8.push_back('{exp8_cur, cyc});
         hold8 = out_valid8 && !out_ready8;
         held8 = dataout8;
      end
   end

   logic        hold32 = 1'b0;
   logic [31:0] held32 = '0;
   always @(negedge clk) begin
      item_t it;
      if (rst) begin
         check("rst_in_ready32", in_ready32, 0);
         q32.delete();
         hold32 = 1'b0;
      end else begin
         check("in_ready32", in_ready32, !out_valid32 || out_ready32);
         if (hold32) begin
            check("stall_valid32", out_valid32, 1);
            check("stall_data32", dataout32, held32);
         end
         if (out_valid32 && out_ready32) begin
            if (q32.size() == 0) check("unexpected_out32", out_valid32, 0);
            else begin
               it = q32.pop_front();
               check("data32", dataout32, it.exp);
               check("zero32", out_zero32, it.exp == 0);
               if (lat_chk32) check("latency32", cyc - it.cyc, 5);
            end
         end
         if (in_valid32 && in_ready32) q32.push_back('{exp32_cur, cyc});
         hold32 = out_valid32 && !out_ready32;
         held32 = dataout32;
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (rnd_rdy) begin
         out_ready8  = ($urandom_range(0, 2) != 0);
         out_ready32 = ($urandom_range(0, 3) != 0);
      end
   end

   // Drive one op and hold it until accepted; returns at posedge+1 of the next cycle.
   task automatic send8(input logic [7:0] d, input logic [2:0] a,
                        input logic [2:0] t, input logic [7:0] e);
      bit acc;
      acc = 0;
      in_valid8 = 1'b1; datain8 = d; shamt8 = a; type8 = t; exp8_cur = e;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         acc = in_ready8;
         @(posedge clk);
         #1;
         if (acc) return;
      end
      check("accept_timeout8", acc, 1);
   endtask

   task automatic send32(input logic [31:0] d, input logic [4:0] a,
                         input logic [2:0] t, input logic [31:0] e);
      bit acc;
      acc = 0;
      in_valid32 = 1'b1; datain32 = d; shamt32 = a; type32 = t; exp32_cur = e;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         acc = in_ready32;
         @(posedge clk);
         #1;
         if (acc) return;
      end
      check("accept_timeout32", acc, 1);
   endtask

   task automatic drain();
      in_valid8  = 1'b0;
      in_valid32 = 1'b0;
      for (int n = 0; n < 300 && (q8.size() != 0 || q32.size() != 0); n++) begin
         @(posedge clk);
         #1;
      end
      check("drain8", q8.size(), 0);
      check("drain32", q32.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  d8;
      logic [31:0] d32;
      logic [2:0]  a8, t;
      logic [4:0]  a32;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid8", out_valid8, 0);
      check("reset_dataout8", dataout8, 0);
      check("reset_out_zero8", out_zero8, 0);
      check("reset_out_valid32", out_valid32, 0);
      check("reset_dataout32", dataout32, 0);
      check("reset_out_zero32", out_zero32, 0);
      @(posedge clk);
      #1;

      // Every mode by 3, back to back, exact latency.
      lat_chk8 = 1;
      send8(8'b11100101, 3'd3, 3'b000, 8'b00101000);
      send8(8'b11100101, 3'd3, 3'b001, 8'b00011100);
      send8(8'b11100101, 3'd3, 3'b010, 8'b11111100);
      send8(8'b11100101, 3'd3, 3'b011, 8'b00101111);
      send8(8'b11100101, 3'd3, 3'b100, 8'b10111100);
      drain();

      // Zero amount is identity; pass-through ignores the amount.
      for (int m = 0; m < 5; m++) send8(8'b11100101, 3'd0, 3'(m), 8'b11100101);
      send8(8'b11100101, 3'd5, 3'b111, 8'b11100101);
      send8(8'b11100101, 3'd7, 3'b101, 8'b11100101);
      drain();

      // Boundary shifts, including an all-zero result.
      send8(8'h01, 3'd7, 3'b000, 8'h80);
      send8(8'h80, 3'd1, 3'b000, 8'h00);
      send8(8'h80, 3'd7, 3'b010, 8'hFF);
      send8(8'h80, 3'd7, 3'b001, 8'h01);
      drain();

      // Back-pressure for 4 cycles in the middle of a 6-op stream.
      lat_chk8 = 0;
      fork
         begin
            repeat (3) @(posedge clk);
            #1 out_ready8 = 1'b0;
            repeat (4) @(posedge clk);
            #1 out_ready8 = 1'b1;
         end
      join_none
      for (int i = 0; i < 6; i++) begin
         d8 = 8'h3C + 8'(i * 17);
         a8 = 3'(i + 1);
         t  = 3'(i % 5);
         send8(d8, a8, t, ref_shift({24'b0, d8}, 8, int'(a8), t) & 32'hFF);
      end
      drain();

      // Reset with three ops in flight: they must vanish.
      send8(8'hA5, 3'd1, 3'b000, 8'h4A);
      send8(8'hA5, 3'd2, 3'b001, 8'h29);
      send8(8'hA5, 3'd3, 3'b011, 8'h2D);
      in_valid8 = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t5_out_valid8", out_valid8, 0);
      @(posedge clk);
      #1;
      lat_chk8 = 1;
      send8(8'h5A, 3'd4, 3'b100, 8'hA5);
      drain();

      // 32-bit wrap-around rotate with 5-cycle latency.
      lat_chk32 = 1;
      send32(32'h8000_0001, 5'd1, 3'b100, 32'hC000_0000);
      send32(32'h8000_0000, 5'd31, 3'b010, 32'hFFFF_FFFF);
      drain();

      // Random traffic against the model with random back-pressure.
      lat_chk8 = 0;
      lat_chk32 = 0;
      rnd_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            in_valid8 = 1'b0;
            @(posedge clk);
            #1;
         end
         d8 = 8'($urandom);
         a8 = 3'($urandom_range(0, 7));
         t  = 3'($urandom_range(0, 7));
         send8(d8, a8, t, ref_shift({24'b0, d8}, 8, int'(a8), t) & 32'hFF);
      end
      in_valid8 = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            in_valid32 = 1'b0;
            @(posedge clk);
            #1;
         end
         d32 = (i % 64 == 0) ? 32'h0 : $urandom;
         a32 = 5'($urandom_range(0, 31));
         t   = 3'($urandom_range(0, 7));
         send32(d32, a32, t, ref_shift(d32, 32, int'(a32), t));
      end
      rnd_rdy = 0;
      out_ready8  = 1'b1;
      out_ready32 = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
